// File: rtl/flp_to_fix_out_pkg.sv
// Shared float-format definitions for the float-to-fixed output stage.
// The input float layout (sign, exponent, mantissa) is fixed here and reused by the top.
package FlpOut_pkg;

  localparam int N_EXP  = 8;
  localparam int N_MANT = 23;
  localparam int BIAS   = 2 ** (N_EXP - 1) - 1;

  localparam logic [N_EXP-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic              sign;
    logic [N_EXP-1:0]  exp;
    logic [N_MANT-1:0] mant;
  } flp_t;

  function automatic flp_t fields_of(input logic [N_EXP+N_MANT:0] raw);
    fields_of = flp_t'(raw);
  endfunction

endpackage

// File: rtl/flp_to_fix_out_sync_fifo.sv
// Small synchronous FIFO holding {sat, data} words; read data is the head entry, forced to 0 when empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int dw    = 17,
  parameter int depth = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [dw-1:0] wdata,
  output logic [dw-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int aw = $clog2(depth);

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [aw:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (aw + 1)'(depth));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array, written on accepted push only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since depth is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flp_to_fix_out.sv
// Float-to-fixed output stage: two-stage conversion pipeline feeding a valid/ready FIFO.
// Build option FLP_OUT_ROUND_EN: round magnitude half away from zero; otherwise truncate.
module flp_to_fix_out
  import FlpOut_pkg::*;
#(
  parameter int n_exp      = N_EXP,
  parameter int n_mant     = N_MANT,
  parameter int out_w      = 16,
  parameter int frac_w     = 15,
  parameter int fifo_depth = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [n_exp+n_mant:0]   in,
  input  logic                    in_valid,
  output logic [out_w-1:0]        out,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf
);

  // Left shifts beyond cl always overflow; w holds {1,mant,half-bit} shifted by up to cl.
  localparam int cl = out_w + 1;
  localparam int w  = n_mant + 2 + cl;

  localparam logic signed [n_exp+1:0] BIAS_S = (n_exp + 2)'(BIAS);
  localparam logic signed [15:0] CL_S  = 16'(cl);
  localparam logic signed [15:0] W_S   = 16'(w);
  localparam logic signed [15:0] OFF_S = 16'(frac_w - n_mant);
  localparam logic [w-1:0] MAX_POS = w'((1 << (out_w - 1)) - 1);
  localparam logic [w-1:0] MAX_NEG = w'(1 << (out_w - 1));
  localparam logic [out_w-1:0] SAT_POS = {1'b0, {(out_w - 1){1'b1}}};
  localparam logic [out_w-1:0] SAT_NEG = {1'b1, {(out_w - 1){1'b0}}};

  flp_t f;
  assign f = fields_of(in);

  logic                    s1_valid;
  logic                    s1_sign;
  logic [n_exp-1:0]        s1_exp;
  logic [n_mant-1:0]       s1_mant;
  logic signed [n_exp+1:0] s1_shift;

  logic                    s2_valid;
  logic [out_w-1:0]        s2_data;
  logic                    s2_sat;

  logic signed [15:0] sh;
  logic signed [15:0] nsh;
  logic [w-1:0]       a_ext;
  logic [w-1:0]       a_sh;
  logic [w-1:0]       mag;
  logic               big;
  logic               over;
  logic [out_w-1:0]   smag;
  logic [out_w-1:0]   conv_data;
  logic               conv_sat;

  logic               full;
  logic               empty;
  logic               pop;

  // S1: unpack the float and remove the exponent bias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_shift <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= f.sign;
        s1_exp   <= f.exp;
        s1_mant  <= f.mant;
        s1_shift <= $signed({2'b00, f.exp}) - BIAS_S;
      end
    end
  end

  // S2 datapath: align {1,mant} to the output LSB, keeping one half-LSB bit for rounding.
  always_comb begin
    sh    = 16'(s1_shift) + OFF_S;
    nsh   = -sh;
    a_ext = w'({1'b1, s1_mant, 1'b0});
    big   = 1'b0;
    a_sh  = '0;
    if (sh >= 16'sd0) begin
      if (sh > CL_S) big = 1'b1;
      else           a_sh = a_ext << sh[7:0];
    end else if (nsh < W_S) begin
      a_sh = a_ext >> nsh[7:0];
    end
`ifdef FLP_OUT_ROUND_EN
    mag = (a_sh >> 1) + w'(a_sh[0]);
`else
    mag = a_sh >> 1;
`endif
    over = big | (s1_sign ? (mag > MAX_NEG) : (mag > MAX_POS));
    smag = s1_sign ? (~mag[out_w-1:0] + 1'b1) : mag[out_w-1:0];

    conv_data = smag;
    conv_sat  = 1'b0;
    if (s1_exp == '0) begin
      conv_data = '0;
    end else if (s1_exp == EXP_ONES[n_exp-1:0]) begin
      conv_sat  = 1'b1;
      conv_data = (s1_mant != '0) ? '0 : (s1_sign ? SAT_NEG : SAT_POS);
    end else if (over) begin
      conv_sat  = 1'b1;
      conv_data = s1_sign ? SAT_NEG : SAT_POS;
    end
  end

  // S2 register: converted sample presented to the FIFO on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= conv_data;
        s2_sat  <= conv_sat;
      end
    end
  end

  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;

  sync_fifo #(
    .dw    (out_w + 1),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_valid),
    .pop   (pop),
    .wdata ({s2_sat, s2_data}),
    .rdata ({out_sat, out}),
    .full  (full),
    .empty (empty)
  );

  // Sticky drop flag: the filter cannot be stalled, so a full FIFO loses the sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          ovf <= 1'b0;
    else if (s2_valid & full & ~pop)   ovf <= 1'b1;
  end

endmodule

// File: tb/tb_flp_to_fix_out.sv
// Self-checking bench for flp_to_fix_out (default parameters); honours FLP_OUT_ROUND_EN.
module tb_flp_to_fix_out;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef FLP_OUT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
    logic        sat;
  } vec_t;

  vec_t vecs[12];

  flp_to_fix_out dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_and_get(input logic [31:0] v, output logic [15:0] o,
                              output logic s, output bit got);
    @(negedge clk);
    in = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    o = '0;
    s = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (out_valid) begin
        got = 1'b1;
        o = out;
        s = out_sat;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk);
    in = 32'h3F000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_valid_k"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_valid_k1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_valid_k2"}, out_valid, 1'b1);
    chk({tag, "_data_k2"}, out, 16'h4000);
    @(posedge clk); #1;
    chk({tag, "_valid_k3"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [15:0] o;
    logic        s;
    bit          got;
    logic [15:0] q5[5];

    vecs[0]  = '{32'h3F000000, 16'h4000, 1'b0};
    vecs[1]  = '{32'hBF800000, 16'h8000, 1'b0};
    vecs[2]  = '{32'h3F800000, 16'h7FFF, 1'b1};
    vecs[3]  = '{32'hFF800000, 16'h8000, 1'b1};
    vecs[4]  = '{32'h7FC00000, 16'h0000, 1'b1};
    vecs[5]  = '{32'h37800000, RND ? 16'h0001 : 16'h0000, 1'b0};
    vecs[6]  = '{32'h00000001, 16'h0000, 1'b0};
    vecs[7]  = '{32'h7F800000, 16'h7FFF, 1'b1};
    vecs[8]  = '{32'hBF000000, 16'hC000, 1'b0};
    vecs[9]  = '{32'h3F7FFFFF, 16'h7FFF, RND};
    vecs[10] = '{32'hBF7FFFFF, RND ? 16'h8000 : 16'h8001, 1'b0};
    vecs[11] = '{32'hC7000000, 16'h8000, 1'b1};

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 16'h0000);
    chk("rst_out_sat", out_sat, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send_and_get(vecs[i].din, o, s, got);
      chk($sformatf("vec%0d_got", i), got, 1'b1);
      chk($sformatf("vec%0d_out", i), o, vecs[i].dout);
      chk($sformatf("vec%0d_sat", i), s, vecs[i].sat);
    end

    repeat (3) @(negedge clk);
    check_latency("lat");

    // Backpressure: 4 held, 5th dropped.
    q5[0] = 16'h4000; q5[1] = 16'h2000; q5[2] = 16'hC000; q5[3] = 16'h0020; q5[4] = 16'h8000;
    @(negedge clk);
    chk("pre_ovf", ovf, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: in = 32'h3F000000;
        1: in = 32'h3E800000;
        2: in = 32'hBF000000;
        3: in = 32'h3A800000;
        default: in = 32'hBF800000;
      endcase
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("full_valid", out_valid, 1'b1);
    chk("full_ovf", ovf, 1'b1);
    chk("full_head", out, q5[0]);
    @(negedge clk);
    chk("full_head_hold", out, q5[0]);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("drain%0d_out", i), out, q5[i]);
      @(negedge clk);
    end
    chk("drain_empty", out_valid, 1'b0);
    chk("drain_ovf_sticky", ovf, 1'b1);

    // Async reset with samples queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in = 32'h3E800000;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("queued_valid", out_valid, 1'b1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_ovf", ovf, 1'b0);
    chk("async_rst_out", out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    check_latency("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
